// File: rtl/ray_tracer_march.sv
// Iterative ray marcher: steps a fixed-point sample point once per cycle and
// tests it against N_OBJ axis-aligned boxes in parallel. It reports the first hit.
module ray_tracer_march #(
  parameter int                 N_OBJ     = 4,
  parameter int                 COORD_W   = 8,
  parameter int                 FRAC_W    = 4,
  parameter int                 DIR_W     = 8,
  parameter int                 COLOR_W   = 12,
  parameter int                 STEP_W    = 8,
  parameter int                 MAX_STEPS = 255,
  parameter logic [COLOR_W-1:0] BG_COLOR  = 12'h000
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [N_OBJ*(COLOR_W+6*COORD_W)-1:0]        in_bus,
  input  logic [3*COORD_W-1:0]                        init,
  input  logic [3*DIR_W-1:0]                          dir,
  output logic                                        busy,
  output logic                                        done,
  output logic [COLOR_W-1:0]                          dout,
  output logic                                        collision_ret,
  output logic [((N_OBJ > 1) ? $clog2(N_OBJ) : 1)-1:0] hit_id,
  output logic [STEP_W-1:0]                           t_out
);

  localparam int OBJ_W = COLOR_W + 6*COORD_W;
  localparam int BUS_W = N_OBJ * OBJ_W;
  localparam int ID_W  = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
  localparam int P_W   = COORD_W + FRAC_W + 1;
  localparam int S_W   = P_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                        state_r, state_nxt_s;
  logic [BUS_W-1:0]              scene_r;
  logic [2:0][DIR_W-1:0]         dir_r;
  logic [2:0][P_W-1:0]           pos_r, pos_nxt_s;
  logic [STEP_W-1:0]             k_r, k_nxt_s;
  logic [2:0][COORD_W-1:0]       pos_int_s;
  logic [2:0][S_W-1:0]           sum_s;
  logic                          out_of_range_s;
  logic [N_OBJ-1:0]              hit_vec_s;
  logic                          hit_any_s;
  logic [ID_W-1:0]               hit_idx_s;
  logic [COLOR_W-1:0]            hit_color_s;
  logic                          load_s;
  logic                          fin_s;
  logic                          res_hit_s;
  logic [ID_W-1:0]               res_id_s;
  logic [COLOR_W-1:0]            res_color_s;

  // Per-box containment test on the integer part of the sample point
  always_comb begin
    for (int a = 0; a < 3; a++) begin
      pos_int_s[a] = pos_r[a][FRAC_W +: COORD_W];
    end
    for (int i = 0; i < N_OBJ; i++) begin
      hit_vec_s[i] = 1'b1;
      for (int a = 0; a < 3; a++) begin
        // Per axis the object holds {lo, hi} with the z axis at the LSBs.
        hit_vec_s[i] = hit_vec_s[i]
          & (scene_r[i*OBJ_W + (2*a+1)*COORD_W +: COORD_W] <= pos_int_s[a])
          & (pos_int_s[a] <= scene_r[i*OBJ_W + 2*a*COORD_W +: COORD_W]);
      end
    end
  end

  // Lowest-index hit wins
  always_comb begin
    hit_any_s   = 1'b0;
    hit_idx_s   = {ID_W{1'b0}};
    hit_color_s = BG_COLOR;
    for (int i = N_OBJ-1; i >= 0; i--) begin
      if (hit_vec_s[i]) begin
        hit_any_s   = 1'b1;
        hit_idx_s   = ID_W'(i);
        hit_color_s = scene_r[i*OBJ_W + 6*COORD_W +: COLOR_W];
      end else begin
        hit_any_s   = hit_any_s;
      end
    end
  end

  // Candidate next position; a negative sum or a carry into the integer MSB+1 leaves space
  always_comb begin
    out_of_range_s = 1'b0;
    for (int a = 0; a < 3; a++) begin
      sum_s[a] = {1'b0, pos_r[a]}
               + {{(S_W-DIR_W){dir_r[a][DIR_W-1]}}, dir_r[a]};
      out_of_range_s = out_of_range_s | sum_s[a][S_W-1] | sum_s[a][S_W-2];
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_nxt_s = state_r;
    pos_nxt_s   = pos_r;
    k_nxt_s     = k_r;
    load_s      = 1'b0;
    fin_s       = 1'b0;
    res_hit_s   = 1'b0;
    res_id_s    = {ID_W{1'b0}};
    res_color_s = BG_COLOR;
    case (state_r)
      IDLE: begin
        if (start) begin
          load_s  = 1'b1;
          k_nxt_s = {STEP_W{1'b0}};
          for (int a = 0; a < 3; a++) begin
            pos_nxt_s[a] = {1'b0, init[a*COORD_W +: COORD_W], {FRAC_W{1'b0}}};
          end
          state_nxt_s = MARCH;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MARCH: begin
        if (hit_any_s) begin
          fin_s       = 1'b1;
          res_hit_s   = 1'b1;
          res_id_s    = hit_idx_s;
          res_color_s = hit_color_s;
          state_nxt_s = DONE;
        end else if ((k_r == STEP_W'(MAX_STEPS)) || out_of_range_s) begin
          fin_s       = 1'b1;
          state_nxt_s = DONE;
        end else begin
          for (int a = 0; a < 3; a++) begin
            pos_nxt_s[a] = sum_s[a][P_W-1:0];
          end
          k_nxt_s = k_r + STEP_W'(1);
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      scene_r       <= {BUS_W{1'b0}};
      dir_r         <= {(3*DIR_W){1'b0}};
      pos_r         <= {(3*P_W){1'b0}};
      k_r           <= {STEP_W{1'b0}};
      busy          <= 1'b0;
      done          <= 1'b0;
      dout          <= {COLOR_W{1'b0}};
      collision_ret <= 1'b0;
      hit_id        <= {ID_W{1'b0}};
      t_out         <= {STEP_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      pos_r   <= pos_nxt_s;
      k_r     <= k_nxt_s;
      busy    <= (state_nxt_s != IDLE);
      done    <= (state_nxt_s == DONE);
      if (load_s) begin
        scene_r <= in_bus;
        dir_r   <= dir;
      end
      if (fin_s) begin
        dout          <= res_color_s;
        collision_ret <= res_hit_s;
        hit_id        <= res_id_s;
        t_out         <= k_r;
      end
    end
  end

endmodule

// File: tb/tb_ray_tracer_march.sv
// Bench for ray_tracer_march: directed vector table, disturbance and reset
// sequences, and randomized rays checked against a scaled-integer march model.
module tb_ray_tracer_march;

  localparam int OBJ_W = 60;
  localparam int BUS_W = 4 * OBJ_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [BUS_W-1:0]  in_bus;
  logic [23:0]       init;
  logic [23:0]       dir;
  logic              busy;
  logic              done;
  logic [11:0]       dout;
  logic              collision_ret;
  logic [1:0]        hit_id;
  logic [7:0]        t_out;

  int pass_cnt  = 0;
  int total_cnt = 0;

  ray_tracer_march dut (
    .clk(clk), .rst(rst), .start(start), .in_bus(in_bus), .init(init), .dir(dir),
    .busy(busy), .done(done), .dout(dout), .collision_ret(collision_ret),
    .hit_id(hit_id), .t_out(t_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BUS_W-1:0] scene;
    logic [23:0]      org;
    logic [23:0]      dv;
    logic [11:0]      col;
    logic             hit;
    logic [1:0]       id;
    logic [7:0]       t;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [OBJ_W-1:0] mk_obj(input logic [11:0] c,
      input logic [7:0] xl, input logic [7:0] xh, input logic [7:0] yl,
      input logic [7:0] yh, input logic [7:0] zl, input logic [7:0] zh);
    return {c, xl, xh, yl, yh, zl, zh};
  endfunction

  // Reference: positions in 1/16 units as plain integers, boxes tested in index order.
  function automatic void ref_march(input logic [BUS_W-1:0] sc, input logic [23:0] org,
      input logic [23:0] dv, output logic [11:0] col, output logic h,
      output logic [1:0] id, output logic [7:0] t);
    int p[3];
    int d[3];
    int np[3];
    bit fin;
    bit outr;
    bit inb;
    logic [OBJ_W-1:0] ob;
    col = 12'h000; h = 1'b0; id = 2'd0; t = 8'd0; fin = 1'b0;
    for (int a = 0; a < 3; a++) begin
      p[a] = int'(org[a*8 +: 8]) * 16;
      d[a] = int'($signed(dv[a*8 +: 8]));
    end
    for (int k = 0; k <= 255 && !fin; k++) begin
      for (int i = 0; i < 4 && !fin; i++) begin
        ob  = sc[i*OBJ_W +: OBJ_W];
        inb = 1'b1;
        for (int a = 0; a < 3; a++) begin
          if (!(int'(ob[(2*a+1)*8 +: 8]) <= p[a] / 16 && p[a] / 16 <= int'(ob[2*a*8 +: 8])))
            inb = 1'b0;
        end
        if (inb) begin
          fin = 1'b1; h = 1'b1; id = i[1:0]; col = ob[48 +: 12]; t = k[7:0];
        end
      end
      if (!fin) begin
        if (k == 255) begin
          fin = 1'b1; t = 8'd255;
        end else begin
          outr = 1'b0;
          for (int a = 0; a < 3; a++) begin
            np[a] = p[a] + d[a];
            if (np[a] < 0 || np[a] >= 4096) outr = 1'b1;
          end
          if (outr) begin
            fin = 1'b1; t = k[7:0];
          end else begin
            for (int a = 0; a < 3; a++) p[a] = np[a];
          end
        end
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Launch one ray, optionally disturb inputs at cycle 'disturb', and check the result.
  task automatic run_and_check(input string nm, input vec_t v, input int disturb);
    int cyc;
    int busy_bad;
    @(posedge clk); #1;
    in_bus = v.scene; init = v.org; dir = v.dv; start = 1'b1;
    cyc = 0; busy_bad = 0;
    @(posedge clk); #1;
    start = 1'b0; cyc = 1;
    while (done !== 1'b1 && cyc < 400) begin
      if (busy !== 1'b1) busy_bad++;
      if (cyc == disturb) begin
        start  = 1'b1;
        in_bus = {4{mk_obj(12'h321, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255)}};
        init   = $urandom; dir = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({nm, " done_cycle"}, cyc, int'(v.t) + 2);
    chk({nm, " busy_in_flight"}, busy_bad, 0);
    chk({nm, " busy_at_done"}, busy, 1'b1);
    chk({nm, " dout"}, dout, v.col);
    chk({nm, " collision_ret"}, collision_ret, v.hit);
    chk({nm, " hit_id"}, hit_id, v.id);
    chk({nm, " t_out"}, t_out, v.t);
    @(posedge clk); #1;
    chk({nm, " done_pulse_end"}, done, 1'b0);
    chk({nm, " busy_after"}, busy, 1'b0);
    chk({nm, " dout_hold"}, dout, v.col);
  endtask

  initial begin
    logic [OBJ_W-1:0] inv;
    vec_t rv;
    int seen_done;

    inv = mk_obj(12'hABC, 8'd1, 8'd0, 8'd0, 8'd255, 8'd0, 8'd255);
    vecs[0] = '{{inv, inv, inv, mk_obj(12'hFFF, 8'd10, 8'd12, 8'd0, 8'd3, 8'd0, 8'd3)},
                24'h000000, 24'h100000, 12'hFFF, 1'b1, 2'd0, 8'd10};
    vecs[1] = '{{inv, mk_obj(12'h00F, 8'd5, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0),
                 mk_obj(12'h0F0, 8'd5, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0), inv},
                24'h000000, 24'h100000, 12'h0F0, 1'b1, 2'd1, 8'd5};
    vecs[2] = '{{inv, inv, inv, inv}, {8'd250, 8'd0, 8'd0}, 24'h100000,
                12'h000, 1'b0, 2'd0, 8'd5};
    vecs[3] = '{{mk_obj(12'h5A5, 8'd0, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0), inv, inv, inv},
                {8'd20, 8'd0, 8'd0}, 24'hE00000, 12'h5A5, 1'b1, 2'd3, 8'd9};
    vecs[4] = '{{inv, inv, inv, inv}, {8'd100, 8'd100, 8'd100}, 24'h000000,
                12'h000, 1'b0, 2'd0, 8'd255};
    vecs[5] = '{{inv, inv, mk_obj(12'h123, 8'd7, 8'd7, 8'd8, 8'd8, 8'd9, 8'd9), inv},
                {8'd7, 8'd8, 8'd9}, 24'h000000, 12'h123, 1'b1, 2'd1, 8'd0};

    rst = 1'b1; start = 1'b0; in_bus = '0; init = 24'h0; dir = 24'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset dout", dout, 12'h000);
    chk("reset collision_ret", collision_ret, 1'b0);
    chk("reset hit_id", hit_id, 2'd0);
    chk("reset t_out", t_out, 8'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i], -1);
    end

    run_and_check("disturbed", vecs[0], 4);

    // Reset in cycle 5 of a ray that would otherwise finish in cycle 12.
    @(posedge clk); #1;
    in_bus = vecs[0].scene; init = vecs[0].org; dir = vecs[0].dv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst done", done, 1'b0);
    chk("midrst busy", busy, 1'b0);
    chk("midrst dout", dout, 12'h000);
    chk("midrst collision_ret", collision_ret, 1'b0);
    chk("midrst hit_id", hit_id, 2'd0);
    chk("midrst t_out", t_out, 8'd0);
    seen_done = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    chk("midrst no_done", seen_done, 0);
    run_and_check("after_rst", vecs[3], -1);

    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < 4; i++) begin
        logic [7:0] lo[3];
        logic [7:0] hi[3];
        for (int a = 0; a < 3; a++) begin
          lo[a] = 8'($urandom_range(0, 255));
          hi[a] = 8'((int'(lo[a]) + int'($urandom_range(0, 80)) > 255) ? 255
                     : int'(lo[a]) + int'($urandom_range(0, 80)));
        end
        if ($urandom_range(0, 7) == 0) begin
          lo[0] = 8'd200; hi[0] = 8'd100;
        end
        rv.scene[i*OBJ_W +: OBJ_W] = mk_obj(12'($urandom), lo[2], hi[2], lo[1], hi[1], lo[0], hi[0]);
      end
      rv.org = 24'($urandom);
      rv.dv  = ($urandom_range(0, 5) == 0) ? 24'h000000 : 24'($urandom);
      ref_march(rv.scene, rv.org, rv.dv, rv.col, rv.hit, rv.id, rv.t);
      run_and_check($sformatf("rand%0d", r), rv, -1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ray_tracer_march.md
Name: ray_tracer_march

Overview:
- Parametrised successor to the single-shot ray tracer: an iterative ray marcher over N_OBJ axis-aligned boxes.
- On `start` it latches a scene, an origin and a fixed-point direction. It then steps the sample point once per cycle and tests all boxes in parallel each step.
- It reports the first hit (colour, object index, step count) or a miss with the background colour.
- It sits between the scene register bank and the pixel colour stage, one ray in flight at a time.

Parameters:
- N_OBJ, 4: number of boxes in the scene.
- COORD_W, 8: integer bits per coordinate (unsigned space 0..2^COORD_W-1).
- FRAC_W, 4: fractional bits of position and direction.
- DIR_W, 8: signed two's-complement width per direction component (includes FRAC_W fraction bits).
- COLOR_W, 12: colour width.
- STEP_W, 8: step counter width.
- MAX_STEPS, 255: last step index evaluated before declaring a miss (must be < 2^STEP_W).
- BG_COLOR, 12'h000: colour on miss.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request a new ray; accepted only when busy=0.
- in_bus  in  N_OBJ*(COLOR_W+6*COORD_W)  scene.
  - Object i occupies slice i; object 0 is at the LSBs.
  - Per object, MSB->LSB: {color, x_lo, x_hi, y_lo, y_hi, z_lo, z_hi}.
- init  in  3*COORD_W  origin {x,y,z}, integer coordinates, fraction taken as 0.
- dir  in  3*DIR_W  direction {dx,dy,dz}, signed fixed point with FRAC_W fraction bits.
- busy  out  1  high while a ray is in flight.
- done  out  1  one-cycle pulse; result outputs valid in that cycle.
- dout  out  COLOR_W  hit colour or BG_COLOR.
- collision_ret  out  1  1 = hit, 0 = miss.
- hit_id  out  clog2(N_OBJ)  index of the hit object, 0 on miss.
- t_out  out  STEP_W  step index of the hit, or of the last evaluated step on a miss.

Behaviour:
- Reset (rst=1 at a clk edge, any state):
  - State goes to IDLE; busy=0, done=0.
  - dout, collision_ret, hit_id and t_out are all cleared to 0.
  - An in-flight ray is discarded; no done pulse is emitted for it.
- States:
  - IDLE:
    - start=1 latches in_bus, init and dir, and clears step k to 0.
    - Position P = {init, FRAC_W'b0} per axis, held as COORD_W+FRAC_W+1 bits (the extra bit is for range detection).
    - Goes to MARCH; busy=1 from the next cycle.
  - MARCH (one step per cycle):
    - Box i hits if lo<=P.int<=hi on all three axes. A box with lo>hi on any axis never hits.
    - Any hit: the lowest index wins. Register dout=color_i, collision_ret=1, hit_id=i, t_out=k; go to DONE.
    - Else if k==MAX_STEPS: miss. Register dout=BG_COLOR, collision_ret=0, hit_id=0, t_out=k; go to DONE.
    - Else compute P' = P + sign-extended dir on each axis.
      - Any axis of P' <0 or >= 2^COORD_W: miss in this same cycle, with t_out=k.
      - Otherwise P<=P', k<=k+1.
  - DONE: done=1 for exactly one cycle; busy=1 during DONE; next state IDLE.
- Latency:
  - start is sampled in cycle 0; step k is evaluated in cycle k+1.
  - done is high in cycle k_final+2.
  - The earliest new start is accepted in the cycle after done.
- Result outputs hold their values until the next done or rst.
- start while busy is ignored and not queued.
- Changes on in_bus, init or dir after acceptance do not affect the ray in flight.
- A zero direction never leaves space: the ray either hits at step 0 or misses at k=MAX_STEPS.
- The hit test has priority over the range check in the same cycle.

Test Plan:
- Hit along +x:
  - Stimulus: origin (0,0,0), dir=(8'h10,0,0) (+1.0); obj0 = FFF, x[10,12], y[0,3], z[0,3]; other boxes lo>hi.
  - Response: done in cycle 12, dout=12'hFFF, collision_ret=1, hit_id=0, t_out=10.
- Priority:
  - Stimulus: obj1 (12'h0F0) and obj2 (12'h00F) both contain the step-5 point (5,0,0), dir +1.0 x.
  - Response: hit_id=1, dout=12'h0F0, t_out=5.
- Leave space:
  - Stimulus: origin x=250, dir +1.0 x, no valid boxes.
  - Response: miss at k=5 (P'=256); done in cycle 7, dout=12'h000, collision_ret=0, t_out=5.
- Negative direction:
  - Stimulus: origin (20,0,0), dx=8'hE0 (-2.0); obj3 = x[0,3], y[0,0], z[0,0].
  - Response: hit at P.x=2, t_out=9, hit_id=3.
- Zero direction, empty origin:
  - Response: miss with t_out=255, done in cycle 257, busy high for cycles 1..257.
- Robustness:
  - Stimulus: pulse start again and change in_bus during MARCH.
  - Response: result unchanged from the undisturbed run.
  - Stimulus: rst at cycle 5 of a run.
  - Response: no done pulse, all outputs 0, busy=0 in the next cycle; a new start is accepted.
